// File: rtl/sersub.sv
// sersub: bit-serial subtractor, out = a - b as a WIDTH+1-bit result, one bit per clock LSB first.
// Latency: done is high in the cycle after edge k+WIDTH when start is accepted on edge k.
// Backpressure: start is taken only while ready (IDLE/DONE); start during RUN is ignored.
// Optional build macro SERSUB_SATURATE_EN: clamp a negative result (final borrow set) to zero.
module sersub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             borrow;
    logic [CW-1:0]    cnt;
    // Holds the WIDTH-1 difference bits produced before the last one; the
    // last bit goes straight into out on the result-writing edge.
    logic [WIDTH-2:0] res;

    logic d;
    logic nb;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign d  = sa[0] ^ sb[0] ^ borrow;
    assign nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

    // Handshake FSM plus serial datapath; out is only written at the end of RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            out    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        res    <= '0;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Right shift keeps the earliest (LSB) difference bit lowest.
                    res    <= (WIDTH-1)'({d, res} >> 1);
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= nb;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
`ifdef SERSUB_SATURATE_EN
                        if (nb) begin
                            out <= '0;
                        end else begin
                            out <= {nb, d, res};
                        end
`else
                        out   <= {nb, d, res};
`endif
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sersub.sv
// tb_sersub: directed checks of sersub (WIDTH=4) against hand-computed results.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Covers reset, latency, wrap/borrow, boundaries, busy protection, back-to-back and mid-op reset.
module tb_sersub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W:0]   out;

    int total = 0;
    int bad   = 0;

    sersub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y};
`ifdef SERSUB_SATURATE_EN
        if (r[W]) r = '0;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: check busy after accept, latency to done, and result.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W:0] exp);
        int n;
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rdy"}, ready, 0);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
            if (done && busy) chk({tag, "_done_busy"}, 1, 0);
        end
        chk({tag, "_lat"}, n, W);
        chk({tag, "_out"}, out, exp);
        step();
        chk({tag, "_idle"}, ready & ~done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int m;
        int dcnt;
        logic [W:0] cap;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        // Reset held for two edges.
        step();
        step();
        chk("rst_out", out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        rst = 1'b0;
        step();

        run_op("basic", 4'd9, 4'd3, 5'd6);
`ifdef SERSUB_SATURATE_EN
        run_op("neg", 4'd3, 4'd9, 5'd0);
        run_op("zero_m15", 4'd0, 4'd15, 5'd0);
`else
        run_op("neg", 4'd3, 4'd9, 5'd26);
        chk("neg_sign", out[W], 1);
        run_op("zero_m15", 4'd0, 4'd15, 5'd17);
`endif
        run_op("eq15", 4'd15, 4'd15, 5'd0);
        run_op("f_m0", 4'd15, 4'd0, 5'd15);

        for (int i = 0; i < 10; i++) begin
            rx = W'($urandom_range(0, 15));
            ry = W'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d", i), rx, ry, model(rx, ry));
        end

        // start and new operands during RUN must be ignored.
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        step();
        a = 4'd0;
        b = 4'd15;
        step();
        step();
        start = 1'b0;
        dcnt = 0;
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                dcnt++;
                cap = out;
            end
            step();
        end
        chk("busy_prot_dones", dcnt, 1);
        chk("busy_prot_out", cap, 6);

        // Back-to-back: start held, new operands presented in the DONE cycle.
        a = 4'd12;
        b = 4'd5;
        start = 1'b1;
        step();
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("b2b_lat1", n, W);
        chk("b2b_out1", out, 7);
        a = 4'd2;
        b = 4'd7;
        step();
        chk("b2b_nobubble_busy", busy, 1);
        chk("b2b_nobubble_rdy", ready, 0);
        start = 1'b0;
        m = 1;
        while (!done && m < 20) begin
            step();
            m++;
        end
        chk("b2b_gap", m, W + 1);
`ifdef SERSUB_SATURATE_EN
        chk("b2b_out2", out, 0);
`else
        chk("b2b_out2", out, 27);
`endif
        step();

        // Reset on the 2nd RUN cycle aborts without a done pulse.
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dcnt++;
            step();
        end
        chk("mid_rst_nodone", dcnt, 0);
        run_op("after_rst", 4'd8, 4'd1, 5'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
